session_reg_resp_tx: RTL and testbench

SESSION_REG_RESP_TX -- requirements
Module: session_reg_resp_tx

---
 rtl/session_reg_resp_tx.sv | 144 ++++++++++++++
 tb/tb_session_reg_resp_tx.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/session_reg_resp_tx.sv
// Session registration response transmitter: captures a parsed request and streams an
// accept/reject Ethernet frame byte-serially. Define RESP_BYTE_CNT_EN to prepend a 2-byte count.
module session_reg_resp_tx #(
    parameter logic [47:0] LOCAL_MAC         = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHER_TYPE        = 16'h88B5,
    parameter logic [15:0] MSG_TYPE_ACCEPT   = 16'h0002,
    parameter logic [15:0] MSG_TYPE_REJECT   = 16'h0003,
    parameter int unsigned MAX_SESSION_ID    = 63,
    parameter logic [7:0]  REJECT_REASON_SID = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_request_id,
    input  logic [7:0]  req_session_id,
    input  logic [47:0] req_src_mac,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        busy,
    output logic [15:0] accept_cnt,
    output logic [15:0] reject_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1
`ifdef RESP_BYTE_CNT_EN
        , StCnt = 2'd2
`endif
    } state_e;

    localparam logic [4:0] LastAccept = 5'd19;
    localparam logic [4:0] LastReject = 5'd20;

    state_e       state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic [47:0]  dest_mac_q;
    logic [31:0]  request_id_q;
    logic         reject_q;
    logic [15:0]  accept_cnt_q, reject_cnt_q;

    logic         capture;
    logic         frame_done;
    logic [4:0]   last_idx;
    logic [167:0] frame;
    logic [7:0]   sel_lsb;

    assign req_ready  = (state_q == StIdle) && !rst;
    assign capture    = req_valid && req_ready;
    assign busy       = (state_q != StIdle);
    assign last_idx   = reject_q ? LastReject : LastAccept;
    assign frame_done = (state_q == StSend) && m_axis_tready && (idx_q == last_idx);
    assign accept_cnt = accept_cnt_q;
    assign reject_cnt = reject_cnt_q;

    // Whole frame as one MSB-first vector; the reason byte sits in the lowest 8 bits and is
    // only reached by reject frames since accept frames stop at index 19.
    assign frame = {dest_mac_q, LOCAL_MAC, ETHER_TYPE,
                    reject_q ? MSG_TYPE_REJECT : MSG_TYPE_ACCEPT,
                    request_id_q, REJECT_REASON_SID};
    assign sel_lsb = 8'd160 - {idx_q, 3'b000};

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = 8'h00;
        unique case (state_q)
            StIdle: begin
                idx_d = '0;
                if (capture) begin
`ifdef RESP_BYTE_CNT_EN
                    state_d = StCnt;
`else
                    state_d = StSend;
`endif
                end
            end
`ifdef RESP_BYTE_CNT_EN
            StCnt: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = idx_q[0] ? (reject_q ? 8'd21 : 8'd20) : 8'h00;
                if (m_axis_tready) begin
                    if (idx_q[0]) begin
                        idx_d   = '0;
                        state_d = StSend;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
`endif
            StSend: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = frame[sel_lsb +: 8];
                m_axis_tlast  = (idx_q == last_idx);
                if (m_axis_tready) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            dest_mac_q   <= '0;
            request_id_q <= '0;
            reject_q     <= 1'b0;
            accept_cnt_q <= '0;
            reject_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                dest_mac_q   <= req_src_mac;
                request_id_q <= req_request_id;
                reject_q     <= 32'(req_session_id) > MAX_SESSION_ID;
            end
            if (frame_done) begin
                if (reject_q) begin
                    if (reject_cnt_q != 16'hFFFF) reject_cnt_q <= reject_cnt_q + 16'd1;
                end else begin
                    if (accept_cnt_q != 16'hFFFF) accept_cnt_q <= accept_cnt_q + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_session_reg_resp_tx.sv
// Self-checking bench for session_reg_resp_tx: random requests and backpressure checked against
// a queue-based frame model.
module tb_session_reg_resp_tx;

    localparam logic [47:0] LOCAL_MAC = 48'h020000000001;
    localparam logic [15:0] ETH_TYPE  = 16'h88B5;
    localparam int          MAX_SID   = 63;
`ifdef RESP_BYTE_CNT_EN
    localparam int OFS = 2;
`else
    localparam int OFS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_request_id;
    logic [7:0]  req_session_id;
    logic [47:0] req_src_mac;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic [15:0] accept_cnt;
    logic [15:0] reject_cnt;

    int checks = 0;
    int failures = 0;
    int exp_acc = 0;
    int exp_rej = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    session_reg_resp_tx dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_request_id(req_request_id),
        .req_session_id(req_session_id),
        .req_src_mac   (req_src_mac),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .accept_cnt    (accept_cnt),
        .reject_cnt    (reject_cnt)
    );

    // Reference frame built field by field from the protocol layout.
    function automatic bit model_frame(input logic [47:0] src, input logic [31:0] rid,
                                       input logic [7:0] sid);
        bit rej;
        int len;
        logic [15:0] msg;
        rej = int'(sid) > MAX_SID;
        len = rej ? 21 : 20;
        msg = rej ? 16'h0003 : 16'h0002;
        exp_q.delete();
`ifdef RESP_BYTE_CNT_EN
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(len));
`endif
        for (int i = 0; i < 6; i++) exp_q.push_back(src[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(LOCAL_MAC[47-8*i -: 8]);
        exp_q.push_back(ETH_TYPE[15:8]);
        exp_q.push_back(ETH_TYPE[7:0]);
        exp_q.push_back(msg[15:8]);
        exp_q.push_back(msg[7:0]);
        for (int i = 0; i < 4; i++) exp_q.push_back(rid[31-8*i -: 8]);
        if (rej) exp_q.push_back(8'h01);
        return rej;
    endfunction

    function automatic void note_frame(input bit rej);
        if (rej) exp_rej = (exp_rej == 65535) ? 65535 : exp_rej + 1;
        else     exp_acc = (exp_acc == 65535) ? 65535 : exp_acc + 1;
    endfunction

    function automatic int first_diff();
        int n;
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
        if (rx_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic randomize_req();
        req_src_mac    = {$urandom_range(0, 65535), $urandom};
        req_request_id = $urandom;
        req_session_id = 8'($urandom_range(0, 255));
    endtask

    // Present a request, wait for capture, then scramble the inputs while the frame is in flight.
    task automatic issue(input logic [47:0] src, input logic [31:0] rid, input logic [7:0] sid);
        req_src_mac    = src;
        req_request_id = rid;
        req_session_id = sid;
        req_valid      = 1'b1;
        for (int k = 0; k < 50 && !req_ready; k++) begin
            @(posedge clk); #1;
        end
        if (!req_ready) begin
            failures++;
            $display("FAIL issue_ready: req_ready=%0b required 1 within 50 cycles", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        randomize_req();
    endtask

    // mode 0: tready=1; mode 1: random; mode 2: random plus a 5-cycle stall on header byte 12.
    // stop_at >= 0 returns with tready=0 while that stream byte is presented.
    task automatic collect(input int mode, input int stop_at);
        int stall_left;
        bit prev_hold;
        bit done;
        logic [7:0] prev_data;
        logic prev_last;
        rx_q.delete();
        stall_left = 5;
        prev_hold  = 0;
        done       = 0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            if (stop_at >= 0 && m_axis_tvalid && rx_q.size() == stop_at) begin
                m_axis_tready = 1'b0;
                return;
            end
            if (mode == 0) m_axis_tready = 1'b1;
            else if (mode == 2 && rx_q.size() == 12 + OFS && stall_left > 0) begin
                m_axis_tready = 1'b0;
                stall_left--;
                checks++;
                if (m_axis_tdata !== 8'h88) begin
                    failures++;
                    $display("FAIL stall_byte12: tdata=%h required 88", m_axis_tdata);
                end
            end else m_axis_tready = 1'($urandom_range(0, 1));
            if (prev_hold) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                    m_axis_tlast !== prev_last) begin
                    failures++;
                    $display("FAIL hold_stable: valid=%b data=%h last=%b required 1 %h %b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
                end
            end
            prev_hold = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                rx_q.push_back(m_axis_tdata);
                if (m_axis_tlast) done = 1;
            end
            @(posedge clk); #1;
        end
        m_axis_tready = 1'b0;
        if (!done) begin
            failures++;
            $display("FAIL collect_timeout: got %0d bytes, required a tlast", rx_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        m_axis_tready = 1'b0;
        randomize_req();
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 8'h00 ||
            busy !== 1'b0 || req_ready !== 1'b0 || accept_cnt !== 16'd0 || reject_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: v=%b l=%b d=%h busy=%b rdy=%b acc=%0d rej=%0d required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, busy, req_ready, accept_cnt,
                     reject_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_accept();
        bit rej;
        int d;
        rej = model_frame(48'hAABBCCDDEEFF, 32'hDEADBEEF, 8'd5);
        issue(48'hAABBCCDDEEFF, 32'hDEADBEEF, 8'd5);
        checks++;
        if (m_axis_tvalid !== 1'b1 || busy !== 1'b1 || m_axis_tdata !== exp_q[0]) begin
            failures++;
            $display("FAIL accept_latency: valid=%b busy=%b data=%h required 1 1 %h",
                     m_axis_tvalid, busy, m_axis_tdata, exp_q[0]);
        end
        collect(0, -1);
        note_frame(rej);
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL accept_frame: %0d bytes, first diff at %0d, required %0d bytes",
                     rx_q.size(), d, exp_q.size());
        end
        checks++;
        if (accept_cnt !== 16'(exp_acc) || req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL accept_after: acc=%0d rdy=%b busy=%b required %0d 1 0",
                     accept_cnt, req_ready, busy, exp_acc);
        end
    endtask

    task automatic test_reject();
        bit rej;
        int d;
        rej = model_frame(48'h112233445566, 32'h01020304, 8'd64);
        issue(48'h112233445566, 32'h01020304, 8'd64);
        collect(0, -1);
        note_frame(rej);
        d = first_diff();
        checks++;
        if (d >= 0 || rx_q.size() != 21 + OFS) begin
            failures++;
            $display("FAIL reject_frame: %0d bytes, first diff at %0d, required %0d bytes",
                     rx_q.size(), d, 21 + OFS);
        end
        checks++;
        if (reject_cnt !== 16'(exp_rej) || accept_cnt !== 16'(exp_acc)) begin
            failures++;
            $display("FAIL reject_cnt: rej=%0d acc=%0d required %0d %0d",
                     reject_cnt, accept_cnt, exp_rej, exp_acc);
        end
        rej = model_frame(48'h0A0B0C0D0E0F, 32'hCAFEF00D, 8'd63);
        issue(48'h0A0B0C0D0E0F, 32'hCAFEF00D, 8'd63);
        collect(1, -1);
        note_frame(rej);
        d = first_diff();
        checks++;
        if (d >= 0 || rx_q.size() != 20 + OFS) begin
            failures++;
            $display("FAIL sid63_accept: %0d bytes, first diff at %0d, required %0d bytes",
                     rx_q.size(), d, 20 + OFS);
        end
        checks++;
        if (accept_cnt !== 16'(exp_acc) || reject_cnt !== 16'(exp_rej)) begin
            failures++;
            $display("FAIL sid63_cnt: acc=%0d rej=%0d required %0d %0d",
                     accept_cnt, reject_cnt, exp_acc, exp_rej);
        end
    endtask

    task automatic test_backpressure();
        bit rej;
        int d;
        logic [47:0] src;
        logic [31:0] rid;
        logic [7:0] sid;
        for (int f = 0; f < 4; f++) begin
            src = {$urandom_range(0, 65535), $urandom};
            rid = $urandom;
            sid = 8'($urandom_range(0, 127));
            rej = model_frame(src, rid, sid);
            issue(src, rid, sid);
            collect(2, -1);
            note_frame(rej);
            d = first_diff();
            checks++;
            if (d >= 0) begin
                failures++;
                $display("FAIL bp_frame%0d: %0d bytes, first diff at %0d, required %0d bytes",
                         f, rx_q.size(), d, exp_q.size());
            end
        end
        checks++;
        if (accept_cnt !== 16'(exp_acc) || reject_cnt !== 16'(exp_rej)) begin
            failures++;
            $display("FAIL bp_cnt: acc=%0d rej=%0d required %0d %0d",
                     accept_cnt, reject_cnt, exp_acc, exp_rej);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a[$], exp_b[$], rx_a[$], rx_b[$];
        logic [47:0] src_b;
        logic [31:0] rid_b;
        logic [7:0] sid_b;
        bit rej_a, rej_b;
        int frame_n, last_k, cap_k, d;
        frame_n = 0;
        last_k = -1;
        cap_k = -1;
        randomize_req();
        src_b = {$urandom_range(0, 65535), $urandom};
        rid_b = $urandom;
        sid_b = 8'($urandom_range(0, 255));
        rej_a = model_frame(req_src_mac, req_request_id, req_session_id);
        exp_a = exp_q;
        rej_b = model_frame(src_b, rid_b, sid_b);
        exp_b = exp_q;
        req_valid = 1'b1;
        for (int k = 0; k < 20 && !req_ready; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_src_mac    = src_b;
        req_request_id = rid_b;
        req_session_id = sid_b;
        for (int k = 0; k < 600 && frame_n < 2; k++) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            if (req_valid && req_ready) cap_k = k;
            if (m_axis_tvalid && m_axis_tready) begin
                if (frame_n == 0) rx_a.push_back(m_axis_tdata);
                else rx_b.push_back(m_axis_tdata);
                if (m_axis_tlast) begin
                    if (frame_n == 0) last_k = k;
                    frame_n++;
                end
            end
            @(posedge clk); #1;
            if (cap_k == k) begin
                req_valid = 1'b0;
                randomize_req();
            end
        end
        req_valid = 1'b0;
        m_axis_tready = 1'b0;
        note_frame(rej_a);
        note_frame(rej_b);
        checks++;
        if (last_k < 0 || cap_k - last_k != 1) begin
            failures++;
            $display("FAIL b2b_gap: capture at %0d, first tlast at %0d, required gap 1",
                     cap_k, last_k);
        end
        rx_q = rx_a;
        exp_q = exp_a;
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL b2b_frame_a: %0d bytes, first diff at %0d", rx_q.size(), d);
        end
        rx_q = rx_b;
        exp_q = exp_b;
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL b2b_frame_b: %0d bytes, first diff at %0d", rx_q.size(), d);
        end
        checks++;
        if (accept_cnt !== 16'(exp_acc) || reject_cnt !== 16'(exp_rej)) begin
            failures++;
            $display("FAIL b2b_cnt: acc=%0d rej=%0d required %0d %0d",
                     accept_cnt, reject_cnt, exp_acc, exp_rej);
        end
    endtask

    task automatic test_mid_reset();
        bit rej;
        int d;
        logic [47:0] src;
        logic [31:0] rid;
        logic [7:0] sid;
        src = {$urandom_range(0, 65535), $urandom};
        rid = $urandom;
        sid = 8'($urandom_range(0, 255));
        issue(src, rid, sid);
        collect(1, 9);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_acc = 0;
        exp_rej = 0;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || busy !== 1'b0 ||
            req_ready !== 1'b0 || accept_cnt !== 16'd0 || reject_cnt !== 16'd0) begin
            failures++;
            $display("FAIL midrst_state: v=%b l=%b busy=%b rdy=%b acc=%0d rej=%0d required all 0",
                     m_axis_tvalid, m_axis_tlast, busy, req_ready, accept_cnt, reject_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ready: req_ready=%b required 1", req_ready);
        end
        src = {$urandom_range(0, 65535), $urandom};
        rid = $urandom;
        sid = 8'($urandom_range(0, 255));
        rej = model_frame(src, rid, sid);
        issue(src, rid, sid);
        collect(1, -1);
        note_frame(rej);
        d = first_diff();
        checks++;
        if (d >= 0) begin
            failures++;
            $display("FAIL midrst_frame: %0d bytes, first diff at %0d, required %0d bytes",
                     rx_q.size(), d, exp_q.size());
        end
        checks++;
        if (accept_cnt !== 16'(exp_acc) || reject_cnt !== 16'(exp_rej)) begin
            failures++;
            $display("FAIL midrst_cnt: acc=%0d rej=%0d required %0d %0d",
                     accept_cnt, reject_cnt, exp_acc, exp_rej);
        end
    endtask

    // Frame header/length per sessionID class: count bytes lead when the count build is enabled.
    task automatic test_frame_length();
        bit rej;
        logic [7:0] sids [2];
        sids[0] = 8'd0;
        sids[1] = 8'd200;
        for (int i = 0; i < 2; i++) begin
            rej = model_frame(48'h001122334455, 32'h89ABCDEF, sids[i]);
            issue(48'h001122334455, 32'h89ABCDEF, sids[i]);
            collect(1, -1);
            note_frame(rej);
            checks++;
            if (rx_q.size() != (rej ? 21 : 20) + OFS || rx_q[0] !== exp_q[0] ||
                rx_q[1] !== exp_q[1]) begin
                failures++;
                $display("FAIL length_sid%0d: %0d bytes first %h %h, required %0d bytes %h %h",
                         sids[i], rx_q.size(), rx_q[0], rx_q[1], (rej ? 21 : 20) + OFS,
                         exp_q[0], exp_q[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_reject();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_frame_length();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
